imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
//  Controller that shares the instruction memory between the fetch stage and a byte-stream
//  program loader (debug UART side). On a load request it halts the PC, drains the pipeline,
//  packs incoming bytes into big-endian 32-bit words and writes them sequentially from
//  address 0, then clears the PC and hands the memory back to fetch.
// PARAMETERS
//  IMEM_DEPTH    256  instruction memory depth in 32-bit words (power of 2)
//  DRAIN_CYCLES  4    cycles PC is held before the first write (pipeline depth after IF)
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  reset         in   1   asynchronous, active-low reset
//  i_load_req    in   1   level; sampled only in IDLE, starts a load session
//  i_byte_valid  in   1   loader byte valid
//  i_byte        in   8   loader byte; first byte of a word is bits [31:24]
//  i_byte_last   in   1   qualifies i_byte: final byte of the program
//  o_byte_ready  out  1   controller accepts byte when valid&ready
//  i_fetch_pc    in   32  PC from the fetch stage
//  o_imem_addr   out  32  byte address to instruction memory
//  o_imem_we     out  1   one-cycle write strobe
//  o_imem_wdata  out  32  packed word
//  o_if_halt     out  1   drives IF PC halt
//  o_pipe_flush  out  1   flushes IF/ID..MEM/WB pipeline registers
//  o_pc_clear    out  1   one-cycle pulse: PC <= 0
//  o_load_busy   out  1   high in every state except IDLE
//  o_load_done   out  1   one-cycle pulse at session end
//  o_load_err    out  1   sticky overflow flag, cleared on next accepted i_load_req
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except o_imem_addr = i_fetch_pc; word index, byte count,
//   drain counter, packer all 0. Reset mid-session abandons it; partially packed word dropped.
//  IDLE: o_imem_addr = i_fetch_pc (combinational); o_byte_ready=0. i_load_req=1 -> DRAIN,
//   err cleared, word index 0.
//  DRAIN: o_if_halt=1, o_pipe_flush=1; counter DRAIN_CYCLES-1 down to 0, then -> LOAD.
//   Exactly DRAIN_CYCLES cycles in DRAIN.
//  LOAD: o_if_halt=1, o_byte_ready=1. Each handshake shifts byte into packer (big-endian).
//   On 4th byte, or on i_byte_last with 1..3 bytes (low bytes zero-padded), the word is
//   registered and o_imem_we=1 the NEXT cycle with o_imem_addr = {word_idx,2'b00};
//   word_idx increments on the write. A byte accepted in the write cycle starts the next word
//   (no bubble). o_imem_addr = write address in LOAD/RELEASE regardless of we.
//  Overflow: write requested with word_idx == IMEM_DEPTH -> we suppressed, o_load_err=1,
//   remaining bytes still accepted and discarded until i_byte_last.
//  i_byte_last accepted -> final write (if any) issued, then -> RELEASE.
//  RELEASE (1 cycle): o_if_halt=1, o_pipe_flush=1, o_pc_clear=1, o_load_done=1 -> IDLE.
//   First fetch from address 0 occurs the cycle after RELEASE.
//  i_load_req while busy is ignored; i_byte_valid outside LOAD is ignored (ready=0).
//  Empty program impossible: session ends only on a byte with i_byte_last.
//  word_idx width clog2(IMEM_DEPTH)+1 so IMEM_DEPTH is representable (no wrap to 0).
// STRUCTURE
//  mips_pkg.vh: state encodings LDC_IDLE/LDC_DRAIN/LDC_LOAD/LDC_RELEASE, BYTES_PER_WORD=4.
//  Sub-module word_packer: byte shift register + count, outputs word/word_valid, handles
//   zero-padding on last; controller holds FSM, drain counter, word index, address mux.
//  Outputs o_imem_we/o_imem_wdata/o_pc_clear/o_load_done registered; o_imem_addr muxed.
// TESTING
//  1 Reset low mid-LOAD after 2 bytes -> IDLE, we never pulses, o_imem_addr follows fetch PC.
//  2 Req, DRAIN_CYCLES=4 -> halt+flush exactly 4 cycles, ready rises cycle 5.
//  3 Bytes 3C,01,10,01,20,42,00,05(last) back-to-back -> writes 0x3C011001@0x0,
//    0x20420005@0x4, one RELEASE cycle with pc_clear+done, then IDLE.
//  4 Six bytes AA..FF, last on 6th -> writes 0xAABBCCDD@0x0, 0xEEFF0000@0x4.
//  5 IMEM_DEPTH=2, 12 bytes -> two writes (0x0,0x4), third suppressed, o_load_err=1 held
//    after done, cleared by next i_load_req.
//  6 i_load_req pulsed during LOAD and bytes valid in IDLE -> no effect, no handshake.

Source files
------------

// File: rtl/imem_load_ctrl_pkg.sv
// rtl/imem_load_ctrl_pkg.sv - shared types and constants for the instruction-memory load controller
//
// Purpose : controller state encoding, word geometry and the byte-alignment
//           helper used by the word packer.
// Ports   : none (package).
package imem_load_ctrl_pkg;

  typedef enum logic [1:0] {
    LDC_IDLE    = 2'd0,
    LDC_DRAIN   = 2'd1,
    LDC_LOAD    = 2'd2,
    LDC_RELEASE = 2'd3
  } ldc_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  // low_aligned carries (held + 1) bytes in its least significant bytes, oldest
  // byte highest. Shifting left puts the oldest byte at [31:24] and leaves the
  // unused low bytes zero, which is exactly the padding a short last word needs.
  function automatic logic [31:0] align_word(input logic [31:0]           low_aligned,
                                             input logic [BYTE_CNT_W-1:0] held);
    return low_aligned << (8 * (BYTES_PER_WORD - 1 - int'(held)));
  endfunction

endpackage

// File: rtl/imem_load_ctrl_word_packer.sv
// rtl/imem_load_ctrl_word_packer.sv - big-endian byte-to-word packer with zero padding on last
//
// Purpose : collects accepted bytes into a 32-bit word, first byte in [31:24].
//           A word completes on the 4th byte or on a byte flagged last; the
//           completed word is presented combinationally in the handshake cycle.
// Ports   : clk, reset (async, active low)
//           i_fire       byte handshake this cycle
//           i_byte       byte value
//           i_last       byte is the final byte of the program
//           o_word       completed (padded) word, valid with o_word_valid
//           o_word_valid word completes on this handshake
module imem_load_ctrl_word_packer
  import imem_load_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_fire,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0]           held_q, held_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  complete;

  assign complete     = i_fire && ((cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1)) || i_last);
  assign o_word_valid = complete;
  // held_q is zeroed after every completed word, so bits above the held bytes are 0.
  assign o_word       = align_word({held_q, i_byte}, cnt_q);

  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    if (complete) begin
      held_d = '0;
      cnt_d  = '0;
    end else if (i_fire) begin
      held_d = {held_q[15:0], i_byte};
      cnt_d  = cnt_q + BYTE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_q <= '0;
      cnt_q  <= '0;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - shares instruction memory between fetch and a byte-stream program loader
//
// Purpose : on a load request halts the PC, drains the pipeline, writes packed
//           words from address 0 upwards, then clears the PC and returns the
//           memory to fetch.
// Ports   : clk, reset (async, active low)
//           i_load_req, i_byte_valid, i_byte[7:0], i_byte_last, o_byte_ready  loader side
//           i_fetch_pc[31:0]                                                  fetch side
//           o_imem_addr[31:0], o_imem_we, o_imem_wdata[31:0]                  memory port
//           o_if_halt, o_pipe_flush, o_pc_clear                               pipeline control
//           o_load_busy, o_load_done, o_load_err                              status
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH   = 256,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load_req,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_last,
  output logic        o_byte_ready,
  input  logic [31:0] i_fetch_pc,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_we,
  output logic [31:0] o_imem_wdata,
  output logic        o_if_halt,
  output logic        o_pipe_flush,
  output logic        o_pc_clear,
  output logic        o_load_busy,
  output logic        o_load_done,
  output logic        o_load_err
);

  // One extra bit so word_idx can hold IMEM_DEPTH itself and overflow is seen.
  localparam int IDX_W = $clog2(IMEM_DEPTH) + 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ldc_state_e       state_q;
  logic [DRN_W-1:0] drain_q;
  logic [IDX_W-1:0] word_idx_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic             pc_clear_q;
  logic             done_q;
  logic             err_q;
  // Set once the last byte is accepted: the following cycle is the final
  // write cycle, during which no further bytes are taken.
  logic             fin_q;

  logic             byte_fire;
  logic             word_valid;
  logic [31:0]      word;
  logic             mem_full;

  assign o_byte_ready = (state_q == LDC_LOAD) && !fin_q;
  assign byte_fire    = i_byte_valid && o_byte_ready;
  assign mem_full     = (word_idx_q == IDX_W'(IMEM_DEPTH));

  imem_load_ctrl_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_fire       (byte_fire),
    .i_byte       (i_byte),
    .i_last       (i_byte_last),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LDC_IDLE;
      drain_q    <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      pc_clear_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      we_q       <= 1'b0;
      pc_clear_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        LDC_IDLE: begin
          if (i_load_req) begin
            state_q    <= LDC_DRAIN;
            drain_q    <= DRN_W'(DRAIN_CYCLES - 1);
            word_idx_q <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            fin_q      <= 1'b0;
          end
        end
        LDC_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= LDC_LOAD;
          end else begin
            drain_q <= drain_q - DRN_W'(1);
          end
        end
        LDC_LOAD: begin
          // The write address is latched with the data so word_idx already
          // points at the next slot while the write is on the bus.
          if (word_valid) begin
            if (mem_full) begin
              err_q <= 1'b1;
            end else begin
              we_q       <= 1'b1;
              wdata_q    <= word;
              addr_q     <= 32'({word_idx_q, 2'b00});
              word_idx_q <= word_idx_q + IDX_W'(1);
            end
          end
          if (byte_fire && i_byte_last) begin
            fin_q <= 1'b1;
          end
          if (fin_q) begin
            fin_q      <= 1'b0;
            state_q    <= LDC_RELEASE;
            pc_clear_q <= 1'b1;
            done_q     <= 1'b1;
          end
        end
        LDC_RELEASE: begin
          state_q <= LDC_IDLE;
        end
        default: begin
          state_q <= LDC_IDLE;
        end
      endcase
    end
  end

  assign o_imem_addr  = (state_q == LDC_IDLE) ? i_fetch_pc : addr_q;
  assign o_imem_we    = we_q;
  assign o_imem_wdata = wdata_q;
  assign o_if_halt    = (state_q != LDC_IDLE);
  assign o_pipe_flush = (state_q == LDC_DRAIN) || (state_q == LDC_RELEASE);
  assign o_pc_clear   = pc_clear_q;
  assign o_load_busy  = (state_q != LDC_IDLE);
  assign o_load_done  = done_q;
  assign o_load_err   = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - self-checking bench for imem_load_ctrl (depth 256 and depth 2 instances)
module tb_imem_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, i_load_req, i_byte_valid, i_byte_last;
  logic [7:0]  i_byte;
  logic [31:0] i_fetch_pc;

  logic        rdy_a, we_a, halt_a, flush_a, pcc_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, wdata_a;
  logic        rdy_b, we_b, halt_b, flush_b, pcc_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, wdata_b;

  imem_load_ctrl #(.IMEM_DEPTH(256), .DRAIN_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .i_load_req(i_load_req), .i_byte_valid(i_byte_valid),
    .i_byte(i_byte), .i_byte_last(i_byte_last), .o_byte_ready(rdy_a), .i_fetch_pc(i_fetch_pc),
    .o_imem_addr(addr_a), .o_imem_we(we_a), .o_imem_wdata(wdata_a), .o_if_halt(halt_a),
    .o_pipe_flush(flush_a), .o_pc_clear(pcc_a), .o_load_busy(busy_a), .o_load_done(done_a),
    .o_load_err(err_a));

  imem_load_ctrl #(.IMEM_DEPTH(2), .DRAIN_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .i_load_req(i_load_req), .i_byte_valid(i_byte_valid),
    .i_byte(i_byte), .i_byte_last(i_byte_last), .o_byte_ready(rdy_b), .i_fetch_pc(i_fetch_pc),
    .o_imem_addr(addr_b), .o_imem_we(we_b), .o_imem_wdata(wdata_b), .o_if_halt(halt_b),
    .o_pipe_flush(flush_b), .o_pc_clear(pcc_b), .o_load_busy(busy_b), .o_load_done(done_b),
    .o_load_err(err_b));

  int errors = 0;
  int checks = 0;

  logic [63:0] wq_a[$], wq_b[$];
  logic [7:0]  prog[$];
  logic [31:0] exp_words[$];
  int cyc = 0, done_cnt_a = 0, done_cnt_b = 0, pcc_cnt_a = 0, shape_bad = 0;
  int last_we_cyc_a = 0, done_cyc_a = 0;
  logic err_after_req_b;

  // Observed memory writes and release pulses, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (we_a) begin wq_a.push_back({addr_a, wdata_a}); last_we_cyc_a = cyc; end
    if (we_b) wq_b.push_back({addr_b, wdata_b});
    if (pcc_a) pcc_cnt_a++;
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
      if (!(pcc_a && halt_a && flush_a && busy_a)) shape_bad++;
    end
    if (done_b) done_cnt_b++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // Reference: bytes grouped four at a time, first byte most significant,
  // a short final group padded with zero low bytes.
  task automatic build_model();
    logic [31:0] w;
    int n;
    exp_words.delete();
    w = 0;
    n = 0;
    for (int i = 0; i < prog.size(); i++) begin
      w = w | (32'(prog[i]) << (8 * (3 - n)));
      n++;
      if (n == 4 || i == prog.size() - 1) begin
        exp_words.push_back(w);
        w = 0;
        n = 0;
      end
    end
  endtask

  task automatic clear_obs();
    wq_a.delete();
    wq_b.delete();
    done_cnt_a = 0; done_cnt_b = 0; pcc_cnt_a = 0; shape_bad = 0;
    last_we_cyc_a = 0; done_cyc_a = 0;
  endtask

  task automatic start_req();
    @(posedge clk); #1;
    i_load_req = 1'b1;
    @(posedge clk); #1;
    i_load_req = 1'b0;
  endtask

  task automatic wait_ready(output bit timed_out);
    int t = 0;
    while (!rdy_a && t < 50) begin @(posedge clk); #1; t++; end
    timed_out = !rdy_a;
  endtask

  task automatic wait_idle(output bit timed_out);
    int t = 0;
    while ((busy_a || busy_b) && t < 50) begin @(posedge clk); #1; t++; end
    timed_out = busy_a || busy_b;
    @(posedge clk); #1;
  endtask

  // Drives one full session from the global prog queue.
  task automatic run_session(input bit gaps, input bit inject_req, output bit timed_out);
    bit to1, to2;
    start_req();
    @(negedge clk);
    err_after_req_b = err_b;
    @(posedge clk); #1;
    wait_ready(to1);
    for (int i = 0; i < prog.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_byte_valid = 1'b0;
        @(posedge clk); #1;
      end
      i_byte_valid = 1'b1;
      i_byte       = prog[i];
      i_byte_last  = (i == prog.size() - 1);
      i_fetch_pc   = $urandom;
      if (inject_req && i == 1) i_load_req = 1'b1;
      @(posedge clk); #1;
      i_load_req = 1'b0;
    end
    i_byte_valid = 1'b0;
    i_byte_last  = 1'b0;
    wait_idle(to2);
    timed_out = to1 || to2;
  endtask

  task automatic test_reset();
    bit to;
    reset = 1'b0;
    i_fetch_pc = 32'h0040_1234;
    @(negedge clk);
    checks++;
    if ({we_a, halt_a, flush_a, pcc_a, busy_a, done_a, err_a, rdy_a} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {we_a, halt_a, flush_a, pcc_a, busy_a, done_a, err_a, rdy_a});
    end
    checks++;
    if (addr_a !== 32'h0040_1234) begin
      errors++; $display("FAIL reset_addr: got %h required %h", addr_a, 32'h0040_1234);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    clear_obs();
    start_req();
    wait_ready(to);
    checks++;
    if (to) begin errors++; $display("FAIL reset_ready_timeout: got ready=0 required 1"); end
    for (int i = 0; i < 2; i++) begin
      i_byte_valid = 1'b1; i_byte = 8'h11 * 8'(i + 1); i_byte_last = 1'b0;
      @(posedge clk); #1;
    end
    i_byte_valid = 1'b0;
    reset = 1'b0;
    i_fetch_pc = 32'h0000_0ABC;
    #2;
    checks++;
    if (busy_a !== 1'b0 || addr_a !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL reset_midload: got busy=%b addr=%h required busy=0 addr=00000abc", busy_a, addr_a);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (wq_a.size() + wq_b.size() != 0) begin
      errors++; $display("FAIL reset_no_write: got %0d writes required 0", wq_a.size() + wq_b.size());
    end
    i_fetch_pc = $urandom;
    #1;
    checks++;
    if (addr_a !== i_fetch_pc || busy_a !== 1'b0) begin
      errors++; $display("FAIL reset_idle_addr: got %h required %h", addr_a, i_fetch_pc);
    end
  endtask

  task automatic test_drain();
    int nd = 0, ready_at = 0;
    bit to;
    clear_obs();
    start_req();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (halt_a && flush_a) nd++;
      if (rdy_a && ready_at == 0) ready_at = k;
    end
    checks++;
    if (nd != 4) begin errors++; $display("FAIL drain_cycles: got %0d required 4", nd); end
    checks++;
    if (ready_at != 5) begin errors++; $display("FAIL drain_ready_cycle: got %0d required 5", ready_at); end
    @(posedge clk); #1;
    i_byte_valid = 1'b1; i_byte = 8'h7E; i_byte_last = 1'b1;
    @(posedge clk); #1;
    i_byte_valid = 1'b0; i_byte_last = 1'b0;
    wait_idle(to);
    checks++;
    if (to || wq_a.size() != 1 || (wq_a.size() == 1 && wq_a[0] !== {32'h0, 32'h7E00_0000})) begin
      errors++;
      $display("FAIL drain_single_byte: got n=%0d w=%h required n=1 w=000000007e000000",
               wq_a.size(), (wq_a.size() > 0) ? wq_a[0] : 64'hx);
    end
  endtask

  task automatic test_programs();
    logic [127:0] v;
    int n, nb;
    bit to;
    logic [63:0] got;
    logic [31:0] lit[2][2];
    lit[0][0] = 32'h3C01_1001; lit[0][1] = 32'h2042_0005;
    lit[1][0] = 32'hAABB_CCDD; lit[1][1] = 32'hEEFF_0000;
    for (int r = 0; r < 10; r++) begin
      prog.delete();
      if (r == 0) begin
        v = 128'h3C01_1001_2042_0005; n = 8;
      end else if (r == 1) begin
        v = 128'hAABB_CCDD_EEFF; n = 6;
      end else begin
        v = {$urandom, $urandom, $urandom, $urandom}; n = $urandom_range(1, 14);
      end
      for (int i = 0; i < n; i++) prog.push_back(v[8 * (n - 1 - i) +: 8]);
      clear_obs();
      run_session(r >= 2, r >= 5, to);
      build_model();
      checks++;
      if (to) begin errors++; $display("FAIL prog%0d_timeout: got busy required idle", r); end
      if (r < 2) begin
        for (int k = 0; k < 2; k++) begin
          got = (k < wq_a.size()) ? wq_a[k] : 64'hx;
          checks++;
          if (got !== {32'(4 * k), lit[r][k]}) begin
            errors++; $display("FAIL prog%0d_lit%0d: got %h required %h", r, k, got, {32'(4 * k), lit[r][k]});
          end
        end
      end
      checks++;
      if (wq_a.size() != exp_words.size()) begin
        errors++; $display("FAIL prog%0d_nwrites_a: got %0d required %0d", r, wq_a.size(), exp_words.size());
      end
      for (int k = 0; k < exp_words.size(); k++) begin
        got = (k < wq_a.size()) ? wq_a[k] : 64'hx;
        checks++;
        if (got !== {32'(4 * k), exp_words[k]}) begin
          errors++; $display("FAIL prog%0d_write_a%0d: got %h required %h", r, k, got, {32'(4 * k), exp_words[k]});
        end
      end
      nb = (exp_words.size() > 2) ? 2 : exp_words.size();
      checks++;
      if (wq_b.size() != nb) begin
        errors++; $display("FAIL prog%0d_nwrites_b: got %0d required %0d", r, wq_b.size(), nb);
      end
      for (int k = 0; k < nb; k++) begin
        got = (k < wq_b.size()) ? wq_b[k] : 64'hx;
        checks++;
        if (got !== {32'(4 * k), exp_words[k]}) begin
          errors++; $display("FAIL prog%0d_write_b%0d: got %h required %h", r, k, got, {32'(4 * k), exp_words[k]});
        end
      end
      checks++;
      if (err_a !== 1'b0 || err_b !== (exp_words.size() > 2)) begin
        errors++;
        $display("FAIL prog%0d_err: got a=%b b=%b required a=0 b=%b", r, err_a, err_b, exp_words.size() > 2);
      end
      checks++;
      if (done_cnt_a != 1 || done_cnt_b != 1 || pcc_cnt_a != 1 || shape_bad != 0) begin
        errors++;
        $display("FAIL prog%0d_release: got done=%0d/%0d pcclr=%0d bad=%0d required 1/1 1 0",
                 r, done_cnt_a, done_cnt_b, pcc_cnt_a, shape_bad);
      end
      checks++;
      if (done_cyc_a != last_we_cyc_a + 1) begin
        errors++;
        $display("FAIL prog%0d_release_after_write: got done cyc %0d required %0d", r, done_cyc_a, last_we_cyc_a + 1);
      end
    end
  endtask

  task automatic test_overflow();
    bit to;
    prog.delete();
    for (int i = 0; i < 12; i++) prog.push_back(8'($urandom));
    clear_obs();
    run_session(1'b0, 1'b0, to);
    build_model();
    checks++;
    if (wq_b.size() != 2 || wq_b[0] !== {32'h0, exp_words[0]} || wq_b[1] !== {32'h4, exp_words[1]}) begin
      errors++; $display("FAIL ovf_writes: got %0d writes required 2 at 0x0/0x4", wq_b.size());
    end
    checks++;
    if (wq_a.size() != 3) begin errors++; $display("FAIL ovf_writes_deep: got %0d required 3", wq_a.size()); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err_b !== 1'b1 || err_a !== 1'b0) begin
      errors++; $display("FAIL ovf_err_sticky: got b=%b a=%b required b=1 a=0", err_b, err_a);
    end
    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(8'($urandom));
    clear_obs();
    run_session(1'b0, 1'b0, to);
    checks++;
    if (err_after_req_b !== 1'b0 || err_b !== 1'b0) begin
      errors++; $display("FAIL ovf_err_clear: got %b/%b required 0/0", err_after_req_b, err_b);
    end
  endtask

  task automatic test_ignore();
    int bad = 0;
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      i_byte_valid = 1'b1; i_byte = 8'($urandom); i_byte_last = 1'($urandom);
      i_fetch_pc = $urandom;
      #1;
      if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || busy_a !== 1'b0 || addr_a !== i_fetch_pc) bad++;
    end
    i_byte_valid = 1'b0; i_byte_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ignore_idle_bytes: got %0d bad cycles required 0", bad); end
    checks++;
    if (wq_a.size() + wq_b.size() + done_cnt_a != 0) begin
      errors++; $display("FAIL ignore_no_activity: got %0d events required 0", wq_a.size() + wq_b.size() + done_cnt_a);
    end
  endtask

  initial begin
    reset = 1'b0; i_load_req = 1'b0; i_byte_valid = 1'b0; i_byte_last = 1'b0;
    i_byte = 8'h00; i_fetch_pc = 32'h0;
    test_reset();
    test_drain();
    test_programs();
    test_overflow();
    test_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
